// File: rtl/dac_pkg.sv
// Shared definitions for the audio output path: modulator mode encoding and
// default widths used by the filter and the pwm_pdm_dac stage.
package dac_pkg;

  localparam int DAC_WIDTH   = 16;
  localparam int DAC_PRESC_W = 8;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_PDM = 1'b1
  } dac_mode_e;

endpackage

// File: rtl/tick_gen.sv
// Modulator rate prescaler: asserts tick once every presc+1 enabled clocks.
// Holds its count at zero while disabled or while the owner requests a clear.
module tick_gen
  import dac_pkg::*;
#(
  parameter int PRESC_W = DAC_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pc_q;
  logic [PRESC_W-1:0] pc_d;
  logic               hit;

  // Compare with >= so lowering presc below the running count fires at once
  // instead of wrapping through the whole counter range.
  assign hit  = (pc_q >= presc);
  assign tick = en && !clr && hit;

  always_comb begin
    pc_d = pc_q + 1'b1;
    if (!en || clr || hit) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/pwm_pdm_dac.sv
// Single-bit output stage: converts the filtered sample stream to either a PWM
// waveform or a first-order delta-sigma (PDM) bit stream for an RC filter.
module pwm_pdm_dac
  import dac_pkg::*;
#(
  parameter int WIDTH   = DAC_WIDTH,
  parameter int PRESC_W = DAC_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               en,
  input  logic               mode,
  input  logic [PRESC_W-1:0] presc,
  output logic               dout,
  output logic               sample
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] acc_q,  acc_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  dac_mode_e        mode_q, mode_d;
  logic             dout_q, dout_d;
  logic             sample_q, sample_d;

  logic             tick;
  logic             mode_chg;
  logic [WIDTH:0]   acc_sum;

  assign mode_chg = (dac_mode_e'(mode) != mode_q);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, hold_q};

  tick_gen #(
    .PRESC_W(PRESC_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (mode_chg),
    .presc(presc),
    .tick (tick)
  );

  // Disable wins over a mode change; a mode change burns one cycle clearing
  // both datapaths so the new modulator always starts from a known state.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hold_d   = hold_q;
    dout_d   = dout_q;
    sample_d = 1'b0;
    mode_d   = dac_mode_e'(mode);

    if (!en) begin
      cnt_d  = '0;
      acc_d  = '0;
      hold_d = din;
      dout_d = 1'b0;
    end else if (mode_chg) begin
      cnt_d  = '0;
      acc_d  = '0;
      dout_d = 1'b0;
    end else if (mode_q == MODE_PWM) begin
      dout_d = (cnt_q < hold_q);
      if (tick) begin
        cnt_d = cnt_q + 1'b1;
        // New duty is only taken at the period boundary so a period is never torn.
        if (cnt_q == CNT_MAX) begin
          hold_d   = din;
          sample_d = 1'b1;
        end
      end
    end else if (tick) begin
      acc_d    = acc_sum[WIDTH-1:0];
      dout_d   = acc_sum[WIDTH];
      hold_d   = din;
      sample_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      hold_q   <= '0;
      mode_q   <= MODE_PWM;
      dout_q   <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      hold_q   <= hold_d;
      mode_q   <= mode_d;
      dout_q   <= dout_d;
      sample_q <= sample_d;
    end
  end

  assign dout   = dout_q;
  assign sample = sample_q;

endmodule
